// File: rtl/gxl01_pkg.sv
// Shared widths, pixel word format and helpers for the GXL01 pixel assembler.
// Build option GXL01_TRANSPARENCY_EN is consumed by gxl01_pixel_assembler.
package gxl01_pkg;

    localparam int PIXEL_W     = 4;
    localparam int ATTR_W      = 6;
    localparam int FIFO_DEPTH  = 4;
    localparam int TILE_PIXELS = 8;

    // FIFO_DEPTH and TILE_PIXELS are powers of two so pointers and the tile counter wrap naturally
    localparam int PTR_W       = $clog2(FIFO_DEPTH);
    localparam int CNT_W       = $clog2(FIFO_DEPTH + 1);
    localparam int TILE_CNT_W  = $clog2(TILE_PIXELS);
    localparam int STALL_LEVEL = FIFO_DEPTH - 1;
    localparam int OUT_W       = ATTR_W + PIXEL_W;

    typedef struct packed {
        logic [ATTR_W-1:0]  attr;
        logic [PIXEL_W-1:0] index;
    } pixel_t;

    typedef enum logic [1:0] {
        SEQ_OK,
        SEQ_STRAY,
        SEQ_RESTART
    } seq_chk_t;

    function automatic logic is_opaque(input pixel_t px);
        return px.index != '0;
    endfunction

endpackage

// File: rtl/gxl01_pixel_fifo.sv
// Small synchronous FIFO of assembled pixels; head entry is read straight from storage.
// A push while full is only taken when a pop frees the head slot in the same cycle.
module gxl01_pixel_fifo
    import gxl01_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  pixel_t           i_wdata,
    output pixel_t           o_rdata,
    output logic             o_full,
    output logic             o_empty,
    output logic [CNT_W-1:0] o_count
);

    pixel_t           r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == CNT_W'(FIFO_DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_rdata   = r_mem[r_rd_ptr];

    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (w_do_pop && !w_do_push) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

    // Storage carries no reset; consumers gate the head with o_empty
    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

endmodule

// File: rtl/gxl01_pixel_assembler.sv
// Assembles bitplane bits plus tile attribute into palette pixels, buffers them and tracks tile sequencing.
// Define GXL01_TRANSPARENCY_EN to drop index-0 pixels from the output stream (they still count toward the tile).
module gxl01_pixel_assembler
    import gxl01_pkg::*;
(
    input  logic               CLK,
    input  logic               RST,
    input  logic [PIXEL_W-1:0] PLANE_IN,
    input  logic               PX_VALID,
    input  logic               TILE_START,
    input  logic [ATTR_W-1:0]  ATTR,
    output logic               PX_STALL,
    output logic               OUT_VALID,
    input  logic               OUT_READY,
    output logic [OUT_W-1:0]   OUT_PIXEL,
    output logic               OUT_OPAQUE,
    output logic               TILE_DONE,
    output logic               ERR_SEQ
);

    logic                  w_pop;
    logic                  w_accept;
    logic                  w_push;
    logic                  w_drop;
    logic                  w_full;
    logic                  w_empty;
    logic [CNT_W-1:0]      w_count;
    pixel_t                w_in_pixel;
    pixel_t                w_head;
    seq_chk_t              w_seq;

    logic [TILE_CNT_W-1:0] r_pix_cnt;
    logic [ATTR_W-1:0]     r_attr;
    logic                  r_tile_done;
    logic                  r_err;

    assign w_pop    = ~w_empty & OUT_READY;
    assign w_accept = PX_VALID & (~w_full | w_pop);
    assign w_drop   = PX_VALID & w_full & ~w_pop;

    assign w_in_pixel.attr  = TILE_START ? ATTR : r_attr;
    assign w_in_pixel.index = PLANE_IN;

`ifdef GXL01_TRANSPARENCY_EN
    assign w_push     = w_accept & is_opaque(w_in_pixel);
    assign OUT_OPAQUE = 1'b1;
`else
    assign w_push     = w_accept;
    assign OUT_OPAQUE = ~w_empty & is_opaque(w_head);
`endif

    gxl01_pixel_fifo u_fifo (
        .i_clk   (CLK),
        .i_rst   (RST),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_wdata (w_in_pixel),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    assign OUT_VALID = ~w_empty;
    assign OUT_PIXEL = w_empty ? '0 : w_head;
    assign PX_STALL  = (w_count >= CNT_W'(STALL_LEVEL));
    assign TILE_DONE = r_tile_done;
    assign ERR_SEQ   = r_err;

    // A stray pixel outside any tile, or a restart in the middle of one
    always_comb begin
        w_seq = SEQ_OK;
        if (PX_VALID) begin
            if (TILE_START && (r_pix_cnt != '0)) begin
                w_seq = SEQ_RESTART;
            end else if (!TILE_START && (r_pix_cnt == '0)) begin
                w_seq = SEQ_STRAY;
            end
        end
    end

    // Counter value 0 means "between tiles"; a stray pixel is buffered but does not open a tile
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_pix_cnt   <= '0;
            r_attr      <= '0;
            r_tile_done <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_tile_done <= 1'b0;
            if (w_accept) begin
                if (TILE_START) begin
                    r_pix_cnt <= TILE_CNT_W'(1);
                    r_attr    <= ATTR;
                end else if (r_pix_cnt != '0) begin
                    r_pix_cnt <= r_pix_cnt + TILE_CNT_W'(1);
                    if (r_pix_cnt == TILE_CNT_W'(TILE_PIXELS - 1)) begin
                        r_tile_done <= 1'b1;
                    end
                end
            end
            if ((w_seq != SEQ_OK) || w_drop) begin
                r_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_gxl01_pixel_assembler.sv
// Self-checking bench for gxl01_pixel_assembler: directed scenarios plus randomized traffic against a queue model.
// Honours GXL01_TRANSPARENCY_EN when compiled with the same define as the design.
module tb_gxl01_pixel_assembler;

`ifdef GXL01_TRANSPARENCY_EN
    localparam bit TRANSP = 1'b1;
`else
    localparam bit TRANSP = 1'b0;
`endif

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [3:0] PLANE_IN = '0;
    logic       PX_VALID = 1'b0;
    logic       TILE_START = 1'b0;
    logic [5:0] ATTR = '0;
    logic       PX_STALL;
    logic       OUT_VALID;
    logic       OUT_READY = 1'b0;
    logic [9:0] OUT_PIXEL;
    logic       OUT_OPAQUE;
    logic       TILE_DONE;
    logic       ERR_SEQ;

    int nTests = 0;
    int nFail  = 0;
    bit checkEn = 1'b0;

    logic [9:0] mQ[$];
    int         mPos = 0;
    logic [5:0] mAttr = '0;
    bit         mErr = 1'b0;
    bit         mDone = 1'b0;
    bit         mPopNow;
    bit         mAccept;

    int         tbPos = 0;
    logic       rRst, rPv, rTs, rRd;
    logic [3:0] rPl;
    logic [5:0] rAt;

    gxl01_pixel_assembler dut (
        .CLK        (CLK),
        .RST        (RST),
        .PLANE_IN   (PLANE_IN),
        .PX_VALID   (PX_VALID),
        .TILE_START (TILE_START),
        .ATTR       (ATTR),
        .PX_STALL   (PX_STALL),
        .OUT_VALID  (OUT_VALID),
        .OUT_READY  (OUT_READY),
        .OUT_PIXEL  (OUT_PIXEL),
        .OUT_OPAQUE (OUT_OPAQUE),
        .TILE_DONE  (TILE_DONE),
        .ERR_SEQ    (ERR_SEQ)
    );

    always #5 CLK = ~CLK;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, let the edge happen, return just after the following falling edge
    task automatic applyStimulus(input logic rst, input logic pv, input logic ts,
                                 input logic [5:0] at, input logic [3:0] pl, input logic rd);
        RST        = rst;
        PX_VALID   = pv;
        TILE_START = ts;
        ATTR       = at;
        PLANE_IN   = pl;
        OUT_READY  = rd;
        @(posedge CLK);
        @(negedge CLK);
        #1;
    endtask

    task automatic doReset();
        applyStimulus(1'b1, 1'b0, 1'b0, 6'h0, 4'h0, 1'b0);
        RST = 1'b0;
    endtask

    // Reference model: a queue of pixel words and a tile position 0..8 (0 = between tiles)
    always @(posedge CLK) begin
        if (RST) begin
            mQ.delete();
            mPos  = 0;
            mAttr = '0;
            mErr  = 1'b0;
            mDone = 1'b0;
        end else begin
            mPopNow = (mQ.size() > 0) && OUT_READY;
            mAccept = 1'b0;
            mDone   = 1'b0;
            if (PX_VALID) begin
                if (TILE_START && mPos != 0) mErr = 1'b1;
                if (!TILE_START && mPos == 0) mErr = 1'b1;
                if (mQ.size() == 4 && !mPopNow) mErr = 1'b1;
                else mAccept = 1'b1;
            end
            if (mPopNow) void'(mQ.pop_front());
            if (mAccept) begin
                if (TILE_START) begin
                    mAttr = ATTR;
                    mPos  = 1;
                end else if (mPos > 0) begin
                    mPos++;
                    if (mPos == 8) begin
                        mDone = 1'b1;
                        mPos  = 0;
                    end
                end
                if (!TRANSP || PLANE_IN != 4'h0) mQ.push_back({mAttr, PLANE_IN});
            end
        end
    end

    always @(negedge CLK) begin
        if (checkEn) begin
            checkOutput("OUT_VALID", 32'(OUT_VALID), 32'(mQ.size() > 0));
            checkOutput("OUT_PIXEL", 32'(OUT_PIXEL), (mQ.size() > 0) ? 32'(mQ[0]) : 32'h0);
            checkOutput("OUT_OPAQUE", 32'(OUT_OPAQUE),
                        TRANSP ? 32'h1 : 32'((mQ.size() > 0) && (mQ[0][3:0] != 4'h0)));
            checkOutput("PX_STALL", 32'(PX_STALL), 32'(mQ.size() >= 3));
            checkOutput("TILE_DONE", 32'(TILE_DONE), 32'(mDone));
            checkOutput("ERR_SEQ", 32'(ERR_SEQ), 32'(mErr));
        end
    end

    initial begin
        @(posedge CLK);
        @(negedge CLK);
        #1;
        RST = 1'b0;
        checkEn = 1'b1;

        checkOutput("rst_valid", 32'(OUT_VALID), 32'h0);
        checkOutput("rst_pixel", 32'(OUT_PIXEL), 32'h0);
        checkOutput("rst_opaque", 32'(OUT_OPAQUE), TRANSP ? 32'h1 : 32'h0);
        checkOutput("rst_stall", 32'(PX_STALL), 32'h0);
        checkOutput("rst_done", 32'(TILE_DONE), 32'h0);
        checkOutput("rst_err", 32'(ERR_SEQ), 32'h0);

        // First pixel of a tile appears one cycle later
        applyStimulus(1'b0, 1'b1, 1'b1, 6'h2A, 4'h5, 1'b1);
        checkOutput("first_valid", 32'(OUT_VALID), 32'h1);
        checkOutput("first_pixel", 32'(OUT_PIXEL), 32'h2A5);
        checkOutput("first_opaque", 32'(OUT_OPAQUE), 32'h1);

        // A full well-formed tile streamed straight through
        doReset();
        for (int i = 1; i <= 8; i++) begin
            applyStimulus(1'b0, 1'b1, (i == 1), 6'h15, 4'(i), 1'b1);
            checkOutput("tile_pixel", 32'(OUT_PIXEL), 32'h150 + 32'(i));
            checkOutput("tile_done_timing", 32'(TILE_DONE), 32'(i == 8));
        end
        checkOutput("tile_err", 32'(ERR_SEQ), 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 6'h0, 4'h0, 1'b1);
        checkOutput("tile_done_pulse", 32'(TILE_DONE), 32'h0);
        checkOutput("tile_drained", 32'(OUT_VALID), 32'h0);

        // Back-pressure: stall at three, full at four, drop at five
        doReset();
        for (int i = 1; i <= 5; i++) begin
            applyStimulus(1'b0, 1'b1, (i == 1), 6'h11, 4'(i), 1'b0);
            checkOutput("bp_stall", 32'(PX_STALL), 32'(i >= 3));
            checkOutput("bp_head_hold", 32'(OUT_PIXEL), 32'h111);
            checkOutput("bp_err", 32'(ERR_SEQ), 32'(i == 5));
        end
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 1'b0, 6'h0, 4'h0, 1'b1);
        checkOutput("bp_empty", 32'(OUT_VALID), 32'h0);

        // Push into a full FIFO accepted because of a same-cycle pop
        doReset();
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, (i == 0), 6'h33, 4'(9 + i), 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 6'h0, 4'hD, 1'b1);
        checkOutput("fullpop_stall", 32'(PX_STALL), 32'h1);
        checkOutput("fullpop_head", 32'(OUT_PIXEL), 32'h33A);
        checkOutput("fullpop_err", 32'(ERR_SEQ), 32'h0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b0, 6'h0, 4'h0, 1'b1);
        checkOutput("fullpop_tail", 32'(OUT_PIXEL), 32'h33D);
        applyStimulus(1'b0, 1'b0, 1'b0, 6'h0, 4'h0, 1'b1);

        // Restart in mid-tile: counter reloads to 1, done after 7 more pixels
        doReset();
        for (int i = 1; i <= 3; i++) applyStimulus(1'b0, 1'b1, (i == 1), 6'h05, 4'(i), 1'b1);
        checkOutput("restart_err_before", 32'(ERR_SEQ), 32'h0);
        applyStimulus(1'b0, 1'b1, 1'b1, 6'h06, 4'h4, 1'b1);
        checkOutput("restart_err", 32'(ERR_SEQ), 32'h1);
        for (int i = 1; i <= 7; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 6'h0, 4'(i), 1'b1);
            checkOutput("restart_done", 32'(TILE_DONE), 32'(i == 7));
        end
        doReset();
        applyStimulus(1'b0, 1'b1, 1'b0, 6'h0, 4'h3, 1'b1);
        checkOutput("stray_err", 32'(ERR_SEQ), 32'h1);

        // Index-0 pixel mid-tile, then reset in mid-tile
        doReset();
        applyStimulus(1'b0, 1'b1, 1'b1, 6'h07, 4'h1, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b0, 6'h0, 4'h0, 1'b1);
        checkOutput("zero_valid", 32'(OUT_VALID), TRANSP ? 32'h0 : 32'h1);
        checkOutput("zero_opaque", 32'(OUT_OPAQUE), TRANSP ? 32'h1 : 32'h0);
        for (int i = 3; i <= 8; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 6'h0, 4'(i), 1'b1);
            checkOutput("zero_done", 32'(TILE_DONE), 32'(i == 8));
        end
        applyStimulus(1'b0, 1'b1, 1'b1, 6'h09, 4'h2, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 6'h0, 4'h3, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 6'h0, 4'h4, 1'b0);
        checkOutput("rst_mid_valid", 32'(OUT_VALID), 32'h0);
        checkOutput("rst_mid_err", 32'(ERR_SEQ), 32'h0);
        RST = 1'b0;

        // Randomized traffic, mostly well-formed tiles with occasional violations and resets
        tbPos = 0;
        for (int c = 0; c < 4000; c++) begin
            rRst = ($urandom_range(0, 499) == 0);
            rPv  = ($urandom_range(0, 9) < 7);
            if (PX_STALL && $urandom_range(0, 9) < 8) rPv = 1'b0;
            rTs  = rPv && ((tbPos == 0) ? ($urandom_range(0, 19) != 0) : ($urandom_range(0, 39) == 0));
            rAt  = 6'($urandom_range(0, 63));
            rPl  = ($urandom_range(0, 4) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            rRd  = ($urandom_range(0, 9) < 6);
            if (rRst) tbPos = 0;
            else if (rPv) tbPos = rTs ? 1 : ((tbPos == 0) ? 0 : (tbPos + 1) % 8);
            applyStimulus(rRst, rPv, rTs, rAt, rPl, rRd);
        end

        checkEn = 1'b0;
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule

// File: doc/gxl01_pixel_assembler.md
GXL01_PIXEL_ASSEMBLER -- requirements
Module: gxl01_pixel_assembler

Interface
REQ-001 SHALL have one clock and one reset; reset is synchronous and active-high; ports CLK and RST.
REQ-002 SHALL have port list:
- CLK  in  1  master clock
- RST  in  1  synchronous active-high reset
- PLANE_IN  in  4  serial bitplane bits from the four shift registers; bit n = plane n, plane 0 = index LSB
- PX_VALID  in  1  PLANE_IN carries a valid pixel this cycle
- TILE_START  in  1  qualifies PX_VALID as the first pixel of an 8-pixel tile
- ATTR  in  6  palette attribute, sampled on TILE_START&PX_VALID
- PX_STALL  out  1  upstream must freeze shifting and hold PX_VALID low
- OUT_VALID  out  1  OUT_PIXEL is valid
- OUT_READY  in  1  consumer accepts OUT_PIXEL
- OUT_PIXEL  out  10  {attr[5:0], index[3:0]}
- OUT_OPAQUE  out  1  index != 0
- TILE_DONE  out  1  one-cycle pulse, tile complete
- ERR_SEQ  out  1  sticky sequencing/overflow error

Function
REQ-003 SHALL accept a pixel when PX_VALID=1 and (FIFO not full, or a pop occurs the same cycle).
REQ-004 SHALL form index = PLANE_IN; attr = ATTR on TILE_START cycles, else the attribute latched at the last TILE_START.
REQ-005 SHALL buffer accepted pixels in a 4-entry FIFO, first in first out.
REQ-006 SHALL present an accepted pixel on OUT_* in the cycle after acceptance when the FIFO was empty (1-cycle latency); no combinational path from PLANE_IN to OUT_*.
REQ-007 SHALL pop on OUT_VALID&OUT_READY; OUT_PIXEL/OUT_OPAQUE SHALL hold stable while OUT_VALID=1 and OUT_READY=0.
REQ-008 SHALL drive PX_STALL combinationally = (occupancy >= 3).
REQ-009 SHALL drop a pixel arriving when full with no same-cycle pop, and set ERR_SEQ.
REQ-010 SHALL keep a 3-bit pixel counter: TILE_START&PX_VALID loads 1; each further accepted pixel increments it; on the 8th pixel the counter wraps to 0.
REQ-011 SHALL pulse TILE_DONE for exactly one cycle, the cycle after the 8th pixel is accepted.
REQ-012 SHALL set ERR_SEQ on: PX_VALID without TILE_START while counter=0; TILE_START while counter!=0 (pixel still accepted, counter restarts at 1).
REQ-013 SHALL clear ERR_SEQ only by reset.

Reset
REQ-014 SHALL, on RST, empty the FIFO and set OUT_VALID=0, OUT_PIXEL=0, OUT_OPAQUE=0, PX_STALL=0, TILE_DONE=0, ERR_SEQ=0, counter=0, latched attr=0.
REQ-015 SHALL let RST override any simultaneous push, pop or TILE_START; in-flight tile data SHALL be discarded.

Configuration
REQ-016 SHALL support macro GXL01_TRANSPARENCY_EN.
REQ-017 With GXL01_TRANSPARENCY_EN defined, pixels with index 0 SHALL be counted toward the tile but not pushed; OUT_OPAQUE SHALL be constant 1.
REQ-018 Without it, every accepted pixel SHALL be pushed and OUT_OPAQUE = (index != 0).

Structure
REQ-019 SHALL take PIXEL_W=4, ATTR_W=6, FIFO_DEPTH=4, TILE_PIXELS=8 and a packed pixel typedef {attr, index} from shared package gxl01_pkg.
REQ-020 SHALL instantiate the FIFO as sub-module gxl01_pixel_fifo (push/pop/full/empty/count); counter, attr latch and error logic stay in the top.

Verification
REQ-021 Reset then TILE_START+ATTR=0x2A, PLANE_IN=0x5, OUT_READY=1 -> next cycle OUT_VALID=1, OUT_PIXEL=0x2A5, OUT_OPAQUE=1.
REQ-022 8 consecutive pixels 0x1..0x8, OUT_READY=1 -> 8 outputs in order, TILE_DONE high one cycle after the 8th, ERR_SEQ=0.
REQ-023 OUT_READY=0, push 3 pixels -> PX_STALL=1 at occupancy 3; a 4th pushed -> full, no drop; a 5th with no pop -> dropped, ERR_SEQ=1.
REQ-024 Full FIFO, PX_VALID and OUT_READY both 1 -> push accepted, occupancy stays 4, ERR_SEQ=0.
REQ-025 TILE_START at pixel 4 of a tile -> ERR_SEQ=1, counter=1, TILE_DONE only after 7 more pixels; PX_VALID with counter=0 and no TILE_START -> ERR_SEQ=1.
REQ-026 Pixel index 0 mid-tile -> with GXL01_TRANSPARENCY_EN no output but TILE_DONE timing unchanged; without it output with OUT_OPAQUE=0; RST mid-tile -> OUT_VALID=0 next cycle.
